vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter H_VIS, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch, in pixels.
REQ-003 Parameter H_SW, default 96, hsync pulse width, in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch; H_TOT = sum of H_* = 800.
REQ-005 Parameter V_VIS, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch, in lines.
REQ-007 Parameter V_SW, default 2, vsync pulse width, in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch; V_TOT = sum of V_* = 525.
REQ-009 clk  in  1  master clock, 100 MHz; the only clock in the block.
REQ-010 clr  in  1  reset; asynchronous, active-high.
REQ-011 dclk  in  1  25 MHz pixel-rate level from the clock divider, synchronous to clk; sampled as data, never used as a clock.
REQ-012 hsync  out  1  horizontal sync, active-low, registered.
REQ-013 vsync  out  1  vertical sync, active-low, registered.
REQ-014 video_on  out  1  high while (x,y) lies in the visible area, registered.
REQ-015 x  out  10  current pixel column, equal to the horizontal count.
REQ-016 y  out  10  current line, equal to the vertical count.
REQ-017 line_tick  out  1  one-clk pulse when the horizontal count wraps to 0.
REQ-018 frame_tick  out  1  one-clk pulse when the counters wrap to (0,0).

Function
REQ-019 The block SHALL register dclk into dclk_q and form the strobe pix_en = dclk & ~dclk_q; at nominal dclk, pix_en is high for 1 clk in every 4.
REQ-020 The block SHALL change counters and outputs only in cycles where pix_en = 1; in all other cycles every output SHALL hold, except the tick outputs.
REQ-021 On pix_en, the horizontal count SHALL increment and wrap from H_TOT-1 to 0.
REQ-022 On pix_en with the horizontal count equal to H_TOT-1, the vertical count SHALL increment and wrap from V_TOT-1 to 0.
REQ-023 hsync, vsync and video_on SHALL be computed from the next-state counter values, so that they stay aligned with x and y in the same cycle.
REQ-024 hsync SHALL be 0 exactly when x is in [H_VIS+H_FP, H_VIS+H_FP+H_SW-1], i.e. [656, 751].
REQ-025 vsync SHALL be 0 exactly when y is in [V_VIS+V_FP, V_VIS+V_FP+V_SW-1], i.e. [490, 491].
REQ-026 video_on SHALL be 1 exactly when x < H_VIS and y < V_VIS.
REQ-027 line_tick SHALL be 1 for the single clk in which x first shows 0; frame_tick likewise when (x,y) first shows (0,0), and line_tick SHALL also pulse in that cycle.
REQ-028 If dclk is held constant, there SHALL be no pix_en, so counters and outputs freeze and no ticks occur.
REQ-029 All counter arithmetic SHALL be unsigned 10-bit; count values of H_TOT or above and V_TOT or above SHALL be unreachable.

Reset
REQ-030 While clr = 1, the block SHALL immediately force: x = H_TOT-1 (799), y = V_TOT-1 (524), hsync = 1, vsync = 1, video_on = 0, line_tick = 0, frame_tick = 0, dclk_q = 0.
REQ-031 The first pix_en after clr deasserts SHALL move the counters to (0,0) and assert line_tick and frame_tick.
REQ-032 Asserting clr in the middle of a frame SHALL abort that frame with no partial-tick glitch; behaviour then follows REQ-031.

Structure
REQ-033 The default timing constants (H_*, V_*, H_TOT, V_TOT) SHALL be defined in the shared package vga_timing_pkg, which vga_sync and downstream pixel generators use.
REQ-034 A sub-module mod_counter SHALL be used twice, for the horizontal and vertical counts. Its ports are clk, clr, en, count and wrap; it has a parameterised modulus and reset value.

Verification
REQ-035 Release clr with dclk toggling every 2 clk -> first pix_en gives x=0, y=0, frame_tick=1, line_tick=1, video_on=1.
REQ-036 Run one full line -> x reaches 799 after 800 pix_en; hsync is low for exactly 96 pix_en (x 656..751); video_on is low from x = 640 onward.
REQ-037 Run one full frame (420000 pix_en) -> vsync is low exactly on lines 490-491; frame_tick occurs once per frame, with a 1,680,000-clk period.
REQ-038 Hold dclk high for 100 clk in the middle of a line -> x and y are unchanged and no ticks occur; counting resumes on the next rising dclk.
REQ-039 Assert clr at x=300, y=200 -> outputs immediately show 799/524/hsync=1/vsync=1/video_on=0; after release, REQ-035 repeats.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants shared by vga_sync and downstream pixel generators.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_VIS = 640;
    localparam int H_FP  = 16;
    localparam int H_SW  = 96;
    localparam int H_BP  = 48;
    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;

    localparam int V_VIS = 480;
    localparam int V_FP  = 10;
    localparam int V_SW  = 2;
    localparam int V_BP  = 33;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

    // True when pos lies in [lo, lo+len-1]; used for the sync pulse windows.
    function automatic logic in_window(input logic [CNT_W-1:0] pos, input int lo, input int len);
        return (int'(pos) >= lo) && (int'(pos) < lo + len);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Enabled modulo-MOD counter with a programmable reset value; wrap flags the terminal count.
module mod_counter #(
    parameter int MOD     = 800,
    parameter int RST_VAL = MOD - 1,
    parameter int W       = 10
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);
    localparam logic [W-1:0] RST  = W'(RST_VAL);

    // wrap is combinational so the next stage can chain its enable in the same cycle.
    assign wrap = (count == LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= RST;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel-rate strobe from dclk, h/v counters, registered syncs and ticks.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int H_VIS = vga_timing_pkg::H_VIS,
    parameter int H_FP  = vga_timing_pkg::H_FP,
    parameter int H_SW  = vga_timing_pkg::H_SW,
    parameter int H_BP  = vga_timing_pkg::H_BP,
    parameter int V_VIS = vga_timing_pkg::V_VIS,
    parameter int V_FP  = vga_timing_pkg::V_FP,
    parameter int V_SW  = vga_timing_pkg::V_SW,
    parameter int V_BP  = vga_timing_pkg::V_BP
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       dclk,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int H_TOT_P = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT_P = V_VIS + V_FP + V_SW + V_BP;

    logic       dclk_q;
    logic       pix_en;
    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;

    assign pix_en = dclk & ~dclk_q;

    // Reset to the last position so the first pixel strobe lands on (0,0) with both ticks.
    mod_counter #(.MOD(H_TOT_P), .RST_VAL(H_TOT_P - 1), .W(10)) u_h_cnt (
        .clk   (clk),
        .clr   (clr),
        .en    (pix_en),
        .count (x),
        .wrap  (h_wrap)
    );

    mod_counter #(.MOD(V_TOT_P), .RST_VAL(V_TOT_P - 1), .W(10)) u_v_cnt (
        .clk   (clk),
        .clr   (clr),
        .en    (pix_en & h_wrap),
        .count (y),
        .wrap  (v_wrap)
    );

    // Next-state counter values: decoding these keeps the syncs aligned with x/y.
    assign h_nxt = h_wrap ? '0 : x + 10'd1;
    assign v_nxt = !h_wrap ? y : (v_wrap ? '0 : y + 10'd1);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dclk_q     <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            video_on   <= 1'b0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            dclk_q     <= dclk;
            line_tick  <= pix_en & h_wrap;
            frame_tick <= pix_en & h_wrap & v_wrap;
            if (pix_en) begin
                hsync    <= ~in_window(h_nxt, H_VIS + H_FP, H_SW);
                vsync    <= ~in_window(v_nxt, V_VIS + V_FP, V_SW);
                video_on <= (int'(h_nxt) < H_VIS) && (int'(v_nxt) < V_VIS);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Randomized scoreboard bench for vga_sync: default-timing instance plus a tiny-timing instance for frame wraps.
module tb_vga_sync;

    localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VV = 6, S_VF = 2, S_VS = 2, S_VB = 3;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       lt;
        logic       ft;
    } obs_t;

    typedef struct {
        int unsigned due;
        obs_t        d;
        obs_t        s;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic dclk = 1'b0;

    logic       d_hs, d_vs, d_vo, d_lt, d_ft;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_vo, s_lt, s_ft;
    logic [9:0] s_x, s_y;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_pix = 0;
    bit          line0 = 1'b0;
    int          hs_low_cnt = 0;
    int          vo_low_cnt = 0;
    exp_t        exp_q[$];
    obs_t        last_d, last_s;

    vga_sync dut (
        .clk(clk), .clr(clr), .dclk(dclk),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
        .x(d_x), .y(d_y), .line_tick(d_lt), .frame_tick(d_ft)
    );

    vga_sync #(
        .H_VIS(S_HV), .H_FP(S_HF), .H_SW(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SW(S_VS), .V_BP(S_VB)
    ) dut_s (
        .clk(clk), .clr(clr), .dclk(dclk),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
        .x(s_x), .y(s_y), .line_tick(s_lt), .frame_tick(s_ft)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: position is simply the (n-1)th pixel of the raster
    function automatic obs_t reset_obs(input int ht, input int vt);
        obs_t o;
        o.x = 10'(ht - 1);
        o.y = 10'(vt - 1);
        o.hs = 1'b1; o.vs = 1'b1; o.vo = 1'b0; o.lt = 1'b0; o.ft = 1'b0;
        return o;
    endfunction

    function automatic obs_t model(input int n, input int hv, input int hf, input int hs, input int hb,
                                   input int vv, input int vf, input int vs, input int vb);
        int ht, vt, l, px, py;
        obs_t o;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        if (n == 0) return reset_obs(ht, vt);
        l  = (n - 1) % (ht * vt);
        px = l % ht;
        py = l / ht;
        o.x  = 10'(px);
        o.y  = 10'(py);
        o.hs = !(px >= hv + hf && px <= hv + hf + hs - 1);
        o.vs = !(py >= vv + vf && py <= vv + vf + vs - 1);
        o.vo = (px < hv) && (py < vv);
        o.lt = (px == 0);
        o.ft = (px == 0) && (py == 0);
        return o;
    endfunction

    function automatic obs_t obs_d();
        return {d_x, d_y, d_hs, d_vs, d_vo, d_lt, d_ft};
    endfunction

    function automatic obs_t obs_s();
        return {s_x, s_y, s_hs, s_vs, s_vo, s_lt, s_ft};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b vo=%b lt=%b ft=%b, required x=%0d y=%0d hs=%b vs=%b vo=%b lt=%b ft=%b",
                     name, $time, got.x, got.y, got.hs, got.vs, got.vo, got.lt, got.ft,
                     exp.x, exp.y, exp.hs, exp.vs, exp.vo, exp.lt, exp.ft);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // driver: one clk per call; a rising dclk predicts a pixel strobe at the next edge
    task automatic drive(input logic d);
        exp_t e;
        @(posedge clk);
        #1;
        if (d && !dclk) begin
            n_pix++;
            e.due = cyc + 1;
            e.d = model(n_pix, 640, 16, 96, 48, 480, 10, 2, 33);
            e.s = model(n_pix, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
            exp_q.push_back(e);
        end
        dclk = d;
    endtask

    task automatic pulse(input int hi, input int lo);
        repeat (hi) drive(1'b1);
        repeat (lo) drive(1'b0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rst_d"}, obs_d(), reset_obs(800, 525));
        check({tag, "_rst_s"}, obs_s(), reset_obs(S_HV + S_HF + S_HS + S_HB, S_VV + S_VF + S_VS + S_VB));
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (clr) begin
            last_d = reset_obs(800, 525);
            last_s = reset_obs(S_HV + S_HF + S_HS + S_HB, S_VV + S_VF + S_VS + S_VB);
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("pix_d", obs_d(), e.d);
            check("pix_s", obs_s(), e.s);
            if (line0 && !d_hs) hs_low_cnt++;
            if (line0 && !d_vo) vo_low_cnt++;
            last_d = e.d; last_d.lt = 1'b0; last_d.ft = 1'b0;
            last_s = e.s; last_s.lt = 1'b0; last_s.ft = 1'b0;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL late_pix: strobe due at cycle %0d not observed, now cycle %0d", e.due, cyc);
            end
            check("hold_d", obs_d(), last_d);
            check("hold_s", obs_s(), last_s);
        end
    end

    // stimulus
    initial begin
        clr  = 1'b1;
        dclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("init");
        @(posedge clk);
        #1;
        clr = 1'b0;

        // one full line at nominal rate
        line0 = 1'b1;
        repeat (800) pulse(2, 2);
        drive(1'b0);
        line0 = 1'b0;
        check_int("line0_hsync_low_pixels", hs_low_cnt, 96);
        check_int("line0_video_off_pixels", vo_low_cnt, 160);

        // freeze mid-line with dclk held high
        repeat (100) pulse(2, 2);
        pulse(100, 2);
        repeat (5) pulse(2, 2);

        // random dclk shapes; the small instance wraps many frames
        repeat (600) pulse($urandom_range(1, 3), $urandom_range(1, 3));

        // advance to x=300 and reset mid-frame
        while (((n_pix - 1) % 800) != 300) pulse(2, 2);
        drive(1'b0);
        drive(1'b0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        check_reset("mid");
        n_pix = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("mid_hold");
        clr = 1'b0;
        repeat (40) pulse(2, 2);

        // drain with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) drive(1'b0);
        check_int("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
